// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: FSM states, owner codes and the
// default tenure limit.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA1 = 2'd2,
        OWN_DMA2 = 2'd3
    } owner_e;

    localparam int unsigned DEFAULT_MAX_HOLD = 16;

    // Encodes a one-hot grant vector (bit0 CPU, bit1 DMA1, bit2 DMA2).
    function automatic owner_e owner_of(input logic [2:0] onehot);
        owner_e code;
        case (onehot)
            3'b001:  code = OWN_CPU;
            3'b010:  code = OWN_DMA1;
            3'b100:  code = OWN_DMA2;
            default: code = OWN_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection: CPU after a DMA tenure, otherwise DMA over
// CPU with round-robin between the two DMA channels.
module bus_arb_pick
    import bus_arb_pkg::*;
(
    input  logic       req_cpu,
    input  logic       req_dma1,
    input  logic       req_dma2,
    input  logic       rr_dma2,
    input  logic       cpu_pref,
    output logic [2:0] win
);

    always_comb begin
        win = 3'b000;
        if (cpu_pref && req_cpu) begin
            win = 3'b001;
        end else if (req_dma1 && req_dma2) begin
            win = rr_dma2 ? 3'b100 : 3'b010;
        end else if (req_dma1) begin
            win = 3'b010;
        end else if (req_dma2) begin
            win = 3'b100;
        end else if (req_cpu) begin
            win = 3'b001;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Three-master bus arbiter with bounded tenures and a one-cycle turnaround
// between owners. All outputs are registered.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req_cpu,
    input  logic       req_dma1,
    input  logic       req_dma2,
    output logic [2:0] gnt,
    output logic       ADE,
    output logic [1:0] owner,
    output logic       preempt
);

    arb_state_e       state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             ade_q, ade_d;
    logic [1:0]       owner_q, owner_d;
    logic             preempt_q, preempt_d;
    logic             rr_dma2_q, rr_dma2_d;
    logic             cpu_pref_q, cpu_pref_d;

    logic [2:0]       win;
    logic             any_req;
    logic             owner_req;
    logic             hold_last;
    logic             grant_now;

    assign any_req   = req_cpu | req_dma1 | req_dma2;
    assign owner_req = |(gnt_q & {req_dma2, req_dma1, req_cpu});
    assign hold_last = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
    // Arbitration happens only when the bus is free (IDLE or TURN).
    assign grant_now = (state_q != ST_OWNED) && any_req;

    bus_arb_pick u_pick (
        .req_cpu  (req_cpu),
        .req_dma1 (req_dma1),
        .req_dma2 (req_dma2),
        .rr_dma2  (rr_dma2_q),
        .cpu_pref (cpu_pref_q),
        .win      (win)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 3'b000;
            hold_cnt_q <= '0;
            ade_q      <= 1'b0;
            owner_q    <= OWN_NONE;
            preempt_q  <= 1'b0;
            rr_dma2_q  <= 1'b0;
            cpu_pref_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
            ade_q      <= ade_d;
            owner_q    <= owner_d;
            preempt_q  <= preempt_d;
            rr_dma2_q  <= rr_dma2_d;
            cpu_pref_q <= cpu_pref_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_OWNED;
            ST_OWNED: if (!owner_req || hold_last) state_d = ST_TURN;
            ST_TURN:  state_d = any_req ? ST_OWNED : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d      = 3'b000;
        hold_cnt_d = '0;
        preempt_d  = 1'b0;
        rr_dma2_d  = rr_dma2_q;
        cpu_pref_d = cpu_pref_q;
        if (grant_now) begin
            gnt_d      = win;
            rr_dma2_d  = win[1] ? 1'b1 : (win[2] ? 1'b0 : rr_dma2_q);
            cpu_pref_d = win[1] | win[2];
        end else if (state_q == ST_OWNED) begin
            if (state_d == ST_OWNED) begin
                gnt_d      = gnt_q;
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else begin
                // Leaving with the request still high can only mean the limit cut it.
                preempt_d = owner_req;
            end
        end
        ade_d   = gnt_d[1] | gnt_d[2];
        owner_d = owner_of(gnt_d);
    end

    assign gnt     = gnt_q;
    assign ADE     = ade_q;
    assign owner   = owner_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: three arbiters (MAX_HOLD 4, 16, 1) share one stimulus
// stream and are checked against an owner/tenure-level reference model.
module tb_bus_arbiter;

    localparam int NDUT = 3;

    typedef struct packed {
        logic [2:0] gnt;
        logic       ade;
        logic [1:0] own;
        logic       pre;
    } exp_t;
    typedef exp_t [NDUT-1:0] exp_vec_t;

    function automatic int hold_of(input int d);
        return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
    endfunction

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic req_cpu  = 1'b0;
    logic req_dma1 = 1'b0;
    logic req_dma2 = 1'b0;

    logic [2:0] gnt_w [NDUT];
    logic       ade_w [NDUT];
    logic [1:0] own_w [NDUT];
    logic       pre_w [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        bus_arbiter #(.MAX_HOLD(hold_of(gi)), .CNT_W(8)) u_dut (
            .CLK      (clk),
            .RST_N    (rst_n),
            .req_cpu  (req_cpu),
            .req_dma1 (req_dma1),
            .req_dma2 (req_dma2),
            .gnt      (gnt_w[gi]),
            .ADE      (ade_w[gi]),
            .owner    (own_w[gi]),
            .preempt  (pre_w[gi])
        );
    end

    always #5 clk = ~clk;

    exp_vec_t exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, for how long, and arbitration history.
    int m_owner     [NDUT];
    int m_cnt       [NDUT];
    int m_last_dma  [NDUT];
    bit m_after_dma [NDUT];
    int m_preempted [NDUT];

    int         glog   [NDUT][16];
    int         glen   [NDUT];
    int         pcount [NDUT];
    logic [1:0] prev_own [NDUT];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    function automatic logic [1:0] code_of(input logic [2:0] g);
        case (g)
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b100:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // r[1]=CPU, r[2]=DMA1, r[3]=DMA2; returns owner code of the winner.
    function automatic int pick_winner(input bit [3:1] r, input int preempted,
                                       input bit after_dma, input int last_dma);
        bit [3:1] cand;
        bit [3:1] others;
        cand = r;
        if (preempted != 0) begin
            others = r & ~(3'b001 << (preempted - 1));
            if (others != 3'b000) cand = others;
        end
        if (cand == 3'b000) return 0;
        if (after_dma && cand[1]) return 1;
        if (cand[2] && cand[3]) return (last_dma == 2) ? 3 : 2;
        if (cand[2]) return 2;
        if (cand[3]) return 3;
        return 1;
    endfunction

    task automatic model_step(input int d, input bit rst, input bit [3:1] r, output exp_t e);
        bit pulse;
        bit still_req;
        pulse = 1'b0;
        still_req = (m_owner[d] != 0) && ((r & (3'b001 << (m_owner[d] - 1))) != 3'b000);
        if (!rst) begin
            m_owner[d]     = 0;
            m_cnt[d]       = 0;
            m_last_dma[d]  = 3;
            m_after_dma[d] = 1'b0;
            m_preempted[d] = 0;
        end else if (m_owner[d] == 0) begin
            m_owner[d]     = pick_winner(r, m_preempted[d], m_after_dma[d], m_last_dma[d]);
            m_cnt[d]       = 0;
            m_preempted[d] = 0;
            if (m_owner[d] == 1) begin
                m_after_dma[d] = 1'b0;
            end else if (m_owner[d] >= 2) begin
                m_after_dma[d] = 1'b1;
                m_last_dma[d]  = m_owner[d];
            end
        end else if (!still_req) begin
            m_owner[d] = 0;
        end else if (m_cnt[d] == hold_of(d) - 1) begin
            m_preempted[d] = m_owner[d];
            m_owner[d]     = 0;
            pulse          = 1'b1;
        end else begin
            m_cnt[d]++;
        end
        e.gnt = (m_owner[d] == 0) ? 3'b000 : 3'(1 << (m_owner[d] - 1));
        e.ade = (m_owner[d] >= 2);
        e.own = 2'(m_owner[d]);
        e.pre = pulse;
    endtask

    task automatic drive(input bit rst, input bit c, input bit a, input bit b);
        exp_vec_t ev;
        exp_t     e;
        @(negedge clk);
        rst_n    = rst;
        req_cpu  = c;
        req_dma1 = a;
        req_dma2 = b;
        for (int d = 0; d < NDUT; d++) begin
            model_step(d, rst, {b, a, c}, e);
            ev[d] = e;
        end
        exp_q.push_back(ev);
    endtask

    task automatic peek(input string name, input int d, input logic [2:0] want);
        @(posedge clk);
        #2;
        check(name, 8'(gnt_w[d]), 8'(want));
    endtask

    task automatic reset_seq();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("reset_gnt dut%0d", d), 8'(gnt_w[d]), 8'd0);
            check($sformatf("reset_owner dut%0d", d), 8'(own_w[d]), 8'd0);
            check($sformatf("reset_pre dut%0d", d), 8'(pre_w[d]), 8'd0);
            glen[d]   = 0;
            pcount[d] = 0;
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_vec_t ev;
        exp_t     e;
        #1;
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                e = ev[d];
                check($sformatf("dut%0d gnt", d), 8'(gnt_w[d]), 8'(e.gnt));
                check($sformatf("dut%0d ADE", d), 8'(ade_w[d]), 8'(e.ade));
                check($sformatf("dut%0d owner", d), 8'(own_w[d]), 8'(e.own));
                check($sformatf("dut%0d preempt", d), 8'(pre_w[d]), 8'(e.pre));
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("dut%0d gnt_onehot0", d), 8'($onehot0(gnt_w[d])), 8'd1);
            check($sformatf("dut%0d ADE_vs_gnt", d), 8'(ade_w[d]), 8'(gnt_w[d][1] | gnt_w[d][2]));
            check($sformatf("dut%0d owner_vs_gnt", d), 8'(own_w[d]), 8'(code_of(gnt_w[d])));
            if (own_w[d] != 2'd0 && prev_own[d] == 2'd0) begin
                $display("[%0t] dut%0d MAX_HOLD=%0d grant owner=%0d", $time, d, hold_of(d), own_w[d]);
                if (glen[d] < 16) glog[d][glen[d]] = int'(own_w[d]);
                glen[d]++;
            end
            if (pre_w[d] === 1'b1) pcount[d]++;
            prev_own[d] = own_w[d];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) prev_own[d] = 2'd0;

        // CPU alone: grant from cycle 1, release at cycle 5, TURN then IDLE.
        reset_seq();
        drive(1, 1, 0, 0);
        peek("s1_cpu_grant", 1, 3'b001);
        check("s1_cpu_owner", 8'(own_w[1]), 8'd1);
        check("s1_cpu_ade", 8'(ade_w[1]), 8'd0);
        for (int i = 1; i < 5; i++) drive(1, 1, 0, 0);
        drive(1, 0, 0, 0);
        peek("s1_turn", 1, 3'b000);
        drive(1, 0, 0, 0);
        peek("s1_idle", 1, 3'b000);

        // All three requesting with MAX_HOLD=4.
        reset_seq();
        for (int i = 0; i < 30; i++) drive(1, 1, 1, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        peek("s2_flush", 0, 3'b000);
        check("s2_grants", 8'(glen[0]), 8'd6);
        check("s2_preempts", 8'(pcount[0]), 8'd6);
        check("s2_order0", 8'(glog[0][0]), 8'd2);
        check("s2_order1", 8'(glog[0][1]), 8'd1);
        check("s2_order2", 8'(glog[0][2]), 8'd3);
        check("s2_order3", 8'(glog[0][3]), 8'd1);
        check("s2_order4", 8'(glog[0][4]), 8'd2);

        // Both DMA channels, CPU idle: alternation.
        reset_seq();
        for (int i = 0; i < 40; i++) drive(1, 0, 1, 1);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        check("s3_grants", 8'(glen[1]), 8'd3);
        check("s3_order0", 8'(glog[1][0]), 8'd2);
        check("s3_order1", 8'(glog[1][1]), 8'd3);
        check("s3_order2", 8'(glog[1][2]), 8'd2);

        // Reset mid-tenure while DMA2 owns.
        reset_seq();
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 1);
        check("s4_owned", 8'(gnt_w[1]), 8'b100);
        drive(0, 0, 0, 1);
        #1;
        check("s4_async_drop", 8'(gnt_w[1]), 8'd0);
        drive(1, 0, 0, 1);
        peek("s4_regrant", 1, 3'b100);

        // Release exactly at hold_cnt = MAX_HOLD-1 is not a preemption.
        reset_seq();
        for (int i = 0; i < 16; i++) drive(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
        check("s5_no_preempt", 8'(pcount[1]), 8'd0);
        check("s5_one_tenure", 8'(glen[1]), 8'd1);

        // Sole requester held past the limit: preempted then re-granted.
        reset_seq();
        for (int i = 0; i < 40; i++) drive(1, 0, 1, 0);
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        check("s6_preempts", 8'(pcount[1]), 8'd2);
        check("s6_regrant0", 8'(glog[1][0]), 8'd2);
        check("s6_regrant1", 8'(glog[1][1]), 8'd2);
        check("s6_regrant2", 8'(glog[1][2]), 8'd2);

        // Random request patterns held for random lengths, with rare resets.
        reset_seq();
        for (int blk = 0; blk < 40; blk++) begin
            bit c;
            bit a;
            bit b;
            int len;
            c   = 1'($urandom_range(0, 1));
            a   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 24));
            if ($urandom_range(0, 19) == 0) drive(0, c, a, b);
            for (int k = 0; k < len; k++) drive(1, c, a, b);
        end
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum consecutive cycles one master may own the bus; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8: hold-counter width.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_cpu  input  1  CPU requests the address/data bus.
REQ-006 SHALL have port req_dma1  input  1  DMA channel 1 request (IO at 1001).
REQ-007 SHALL have port req_dma2  input  1  DMA channel 2 request (IO at 1006).
REQ-008 SHALL have port gnt  output  3  one-hot grant, registered: bit0 CPU, bit1 DMA1, bit2 DMA2.
REQ-009 SHALL have port ADE  output  1  registered; high when gnt[1] or gnt[2] is high (DMA drives the bus).
REQ-010 SHALL have port owner  output  2  registered; 0 none, 1 CPU, 2 DMA1, 3 DMA2.
REQ-011 SHALL have port preempt  output  1  one-cycle pulse when a tenure is cut at MAX_HOLD.

Function
REQ-012 SHALL implement the states IDLE, OWNED and TURN.
REQ-013 IDLE: gnt=0. With any request sampled high, SHALL go to OWNED with the winner's gnt bit high from the next cycle (1-cycle latency).
REQ-014 Arbitration SHALL rank DMA above CPU.
REQ-015 Between DMA1 and DMA2, arbitration SHALL be round-robin: the channel not granted last wins a tie.
REQ-016 If the just-ended tenure was DMA and req_cpu is high, the CPU SHALL win the next arbitration regardless of DMA requests (no CPU starvation).
REQ-017 OWNED: hold_cnt SHALL start at 0 on entry and increment each cycle.
REQ-018 OWNED: gnt SHALL stay while the owner's req is high and hold_cnt < MAX_HOLD-1.
REQ-019 OWNED: owner req low SHALL go to TURN at the next edge.
REQ-020 OWNED: hold_cnt == MAX_HOLD-1 with owner req still high SHALL go to TURN and pulse preempt in the first TURN cycle.
REQ-021 TURN: gnt=0, ADE=0, owner=0 for exactly one cycle (bus turnaround). Then OWNED with a new winner if any request is pending, else IDLE.
REQ-022 A preempted master SHALL NOT be re-granted immediately when another request is pending; if it is the only requester, it SHALL be re-granted after TURN.
REQ-023 gnt SHALL never have more than one bit set; ADE and owner SHALL be consistent with gnt in every cycle.
REQ-024 An owner req falling in the same cycle hold_cnt reaches MAX_HOLD-1 SHALL be a normal release: preempt stays 0.
REQ-025 MAX_HOLD=1 SHALL give one-cycle tenures, each followed by TURN.
REQ-026 Requests from non-owners during OWNED SHALL be ignored until TURN; no mid-tenure switching except via preempt.

Reset
REQ-027 RST_N low SHALL asynchronously force: state IDLE, gnt=0, ADE=0, owner=0, preempt=0, hold_cnt=0, round-robin pointer favouring DMA1, CPU-preference flag 0.
REQ-028 Reset asserted mid-tenure SHALL drop gnt in the same cycle, without a TURN cycle.
REQ-029 After RST_N rises, the first arbitration SHALL occur at the next rising edge.

Structure
REQ-030 Package bus_arb_pkg SHALL hold the state enum, the owner codes (NONE/CPU/DMA1/DMA2) and the default MAX_HOLD.
REQ-031 Winner selection SHALL be one combinational sub-module, bus_arb_pick: inputs are the requests, RR pointer and CPU-preference flag; output is the one-hot winner.

Verification
REQ-032 Bench SHALL cover: req_cpu=1 alone at cycle 0 -> gnt=001, owner=1, ADE=0 from cycle 1; req_cpu low at cycle 5 -> TURN in cycle 6, IDLE in cycle 7.
REQ-033 Bench SHALL cover: all three requests high continuously, MAX_HOLD=4 -> grant order DMA1, CPU, DMA2, CPU, DMA1; each tenure 4 cycles with preempt pulsed; 1-cycle gap between tenures.
REQ-034 Bench SHALL cover: req_dma1 and req_dma2 high with req_cpu low -> alternation DMA1, DMA2, DMA1; ADE=1 only during tenures, 0 in every TURN cycle.
REQ-035 Bench SHALL cover: DMA2 owns, RST_N pulsed low mid-tenure -> gnt=000 immediately; after release with req_dma2 still high, gnt=100 one cycle later.
REQ-036 Bench SHALL cover: owner req falls exactly at hold_cnt=MAX_HOLD-1 -> preempt stays 0. Sole requester held past MAX_HOLD=16 -> preempt, TURN, then re-grant to the same master.
REQ-037 Bench SHALL check, in every cycle, that gnt is one-hot or zero, ADE equals gnt[1] OR gnt[2], and owner matches gnt.
